rs_bank: RTL and testbench
==========================

RS_BANK -- requirements
Module: rs_bank

Interface
REQ-001 Parameter DEPTH, default 4, is the number of station entries (2..16).
REQ-002 Parameter NSRC, default 2, is the number of source operands per entry.
REQ-003 Parameter TAGW, default 4, is the CDB/ROB tag width.
REQ-004 Parameter DATAW, default 8, is the width of operand, wbs, flag, robid and source values.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 disp_valid  in  1  dispatch request.
REQ-008 disp_ready  out  1  high when at least one entry is free; combinational from state only.
REQ-009 disp_operand, disp_wbs, disp_flag, disp_robid  in  DATAW each  instruction payload.
REQ-010 disp_srctag  in  NSRC x TAGW  producer tag per source.
REQ-011 disp_srcrdy  in  NSRC  per-source flag: value already available.
REQ-012 disp_srcval  in  NSRC x DATAW  per-source value, used where disp_srcrdy is 1.
REQ-013 cdb_valid  in  1  CDB broadcast strobe.
REQ-014 cdb_tag  in  TAGW  broadcast tag.
REQ-015 cdb_val  in  DATAW  broadcast value.
REQ-016 iss_valid  out  1  issue register holds an instruction.
REQ-017 iss_ready  in  1  FU accepts the issue register this cycle.
REQ-018 iss_operand, iss_wbs, iss_flag, iss_robid  out  DATAW each  issued payload.
REQ-019 iss_srcval  out  NSRC x DATAW  resolved source values.
REQ-020 flush  in  1  synchronous discard of all entries and the issue register.
REQ-021 occupancy  out  clog2(DEPTH)+1  count of valid entries, excluding the issue register.

Function
REQ-022 Dispatch: a transfer occurs when disp_valid and disp_ready are both high; payload is written into the lowest-indexed free entry.
REQ-023 Each source is ready at dispatch if disp_srcrdy is 1, or if cdb_valid is 1 and cdb_tag equals its disp_srctag in the same cycle (CDB bypass; the CDB value is captured).
REQ-024 Wakeup: each cycle with cdb_valid high, every valid entry source that is not ready and whose tag equals cdb_tag becomes ready and captures cdb_val; several sources and entries may wake on one broadcast.
REQ-025 With cdb_valid low, no tag comparison takes effect, including for tag value 0.
REQ-026 An entry is eligible when valid and all NSRC sources are ready at the start of the cycle.
REQ-027 Select: the issue register loads when it is empty or iss_ready is high; it takes the oldest eligible entry by dispatch order, which is not index order.
REQ-028 A selected entry is freed on the same edge it moves into the issue register.
REQ-029 Latency: an entry dispatched at edge t with all sources ready gives iss_valid high after edge t+1; a CDB wakeup at edge t gives iss_valid after edge t+1.
REQ-030 While iss_valid is high and iss_ready is low, all iss_* outputs hold stable.
REQ-031 Back-to-back issue: with iss_ready held high and eligible entries present, one instruction issues per cycle.
REQ-032 Full: disp_ready is low when all DEPTH entries are valid; an entry freed by select is not reusable until the next cycle.
REQ-033 Empty issue register: iss_valid is low and all iss_* payload outputs are driven to 0.
REQ-034 A flushed cycle: flush has priority over dispatch, wakeup and select; the next edge invalidates all entries, clears iss_valid and zeroes outputs.
REQ-035 A dispatch offered in a flushed cycle is dropped.
REQ-036 occupancy updates each edge as previous value + dispatched - selected; it never exceeds DEPTH.

Reset
REQ-037 While rst is low: all entries are invalid, the age order is cleared, iss_valid=0, all iss_* payloads=0, occupancy=0, and disp_ready=1.
REQ-038 Reset assertion mid-operation discards all state asynchronously, with no partial issue; operation resumes on the first edge after rst rises.

Verification
REQ-039 Dispatch robid=0x11 with srcrdy=2'b11, srcval={0x05,0x07}, iss_ready=1 -> iss_valid one cycle later with iss_robid=0x11 and iss_srcval={0x05,0x07}.
REQ-040 Dispatch robid=0x21 waiting on tag 3, then cdb_valid=1, tag=3, val=0xAA two cycles later -> issue the next cycle with that source=0xAA; cdb_tag=3 with cdb_valid=0 -> no wakeup.
REQ-041 Fill 4 entries waiting on tags 1..4, then broadcast 4,2 -> disp_ready=0 while full; issue order is robid(tag4) then robid(tag2); occupancy goes 4->3->2.
REQ-042 Dispatch waiting on tag 5 in the same cycle as cdb_valid=1, tag=5, val=0x3C -> bypass captured; issue the next cycle with source=0x3C.
REQ-043 Hold iss_ready=0 with 3 ready entries -> iss_* stable; on release, 3 issues on consecutive cycles, oldest first.
REQ-044 Assert flush with 2 valid entries, an occupied issue register and a concurrent dispatch -> next cycle occupancy=0, iss_valid=0, and the dispatch is not stored; repeat the check with rst pulsed low mid-stream.

Source files
------------

// File: rtl/rs_bank.sv
// Reservation-station bank: dispatch into free entries, CDB wakeup with bypass,
// and oldest-ready select into a single registered issue slot.
module rs_bank #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 2,
  parameter int TAGW  = 4,
  parameter int DATAW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [DATAW-1:0]        disp_operand,
  input  logic [DATAW-1:0]        disp_wbs,
  input  logic [DATAW-1:0]        disp_flag,
  input  logic [DATAW-1:0]        disp_robid,
  input  logic [NSRC*TAGW-1:0]    disp_srctag,
  input  logic [NSRC-1:0]         disp_srcrdy,
  input  logic [NSRC*DATAW-1:0]   disp_srcval,
  input  logic                    cdb_valid,
  input  logic [TAGW-1:0]         cdb_tag,
  input  logic [DATAW-1:0]        cdb_val,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [DATAW-1:0]        iss_operand,
  output logic [DATAW-1:0]        iss_wbs,
  output logic [DATAW-1:0]        iss_flag,
  output logic [DATAW-1:0]        iss_robid,
  output logic [NSRC*DATAW-1:0]   iss_srcval,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int OCCW = $clog2(DEPTH) + 1;

  // Entry storage
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DATAW-1:0]  op_q    [DEPTH];
  logic [DATAW-1:0]  op_d    [DEPTH];
  logic [DATAW-1:0]  wbs_q   [DEPTH];
  logic [DATAW-1:0]  wbs_d   [DEPTH];
  logic [DATAW-1:0]  flag_q  [DEPTH];
  logic [DATAW-1:0]  flag_d  [DEPTH];
  logic [DATAW-1:0]  robid_q [DEPTH];
  logic [DATAW-1:0]  robid_d [DEPTH];
  logic [NSRC-1:0]   rdy_q   [DEPTH];
  logic [NSRC-1:0]   rdy_d   [DEPTH];
  logic [TAGW-1:0]   tag_q   [DEPTH][NSRC];
  logic [TAGW-1:0]   tag_d   [DEPTH][NSRC];
  logic [DATAW-1:0]  val_q   [DEPTH][NSRC];
  logic [DATAW-1:0]  val_d   [DEPTH][NSRC];
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];

  // Issue register and occupancy
  logic                   iss_valid_q, iss_valid_d;
  logic [DATAW-1:0]       iss_operand_q, iss_operand_d;
  logic [DATAW-1:0]       iss_wbs_q, iss_wbs_d;
  logic [DATAW-1:0]       iss_flag_q, iss_flag_d;
  logic [DATAW-1:0]       iss_robid_q, iss_robid_d;
  logic [NSRC*DATAW-1:0]  iss_srcval_q, iss_srcval_d;
  logic [OCCW-1:0]        occ_q, occ_d;

  // Per-cycle decision signals
  logic              free_found;
  logic [IDXW-1:0]   free_idx;
  logic [DEPTH-1:0]  elig;
  logic [DEPTH-1:0]  blocked;
  logic              sel_found;
  logic [IDXW-1:0]   sel_idx;
  logic              load_en;
  logic              do_sel;
  logic              do_disp;

  assign disp_ready  = ~&valid_q;
  assign iss_valid   = iss_valid_q;
  assign iss_operand = iss_operand_q;
  assign iss_wbs     = iss_wbs_q;
  assign iss_flag    = iss_flag_q;
  assign iss_robid   = iss_robid_q;
  assign iss_srcval  = iss_srcval_q;
  assign occupancy   = occ_q;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
  end

  // Eligibility uses start-of-cycle readiness; an eligible entry is blocked
  // if any other eligible entry is older.
  always_comb begin
    elig      = '0;
    blocked   = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      elig[i] = valid_q[i] && (&rdy_q[i]);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] && older_q[j][i]) begin
          blocked[i] = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (elig[i] && !blocked[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end

  assign load_en = !iss_valid_q || iss_ready;
  assign do_sel  = load_en && sel_found && !flush;
  assign do_disp = disp_valid && free_found && !flush;

  always_comb begin
    valid_d       = valid_q;
    op_d          = op_q;
    wbs_d         = wbs_q;
    flag_d        = flag_q;
    robid_d       = robid_q;
    rdy_d         = rdy_q;
    tag_d         = tag_q;
    val_d         = val_q;
    older_d       = older_q;
    iss_valid_d   = iss_valid_q;
    iss_operand_d = iss_operand_q;
    iss_wbs_d     = iss_wbs_q;
    iss_flag_d    = iss_flag_q;
    iss_robid_d   = iss_robid_q;
    iss_srcval_d  = iss_srcval_q;
    occ_d         = occ_q;

    if (flush) begin
      valid_d       = '0;
      iss_valid_d   = 1'b0;
      iss_operand_d = '0;
      iss_wbs_d     = '0;
      iss_flag_d    = '0;
      iss_robid_d   = '0;
      iss_srcval_d  = '0;
      occ_d         = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        older_d[i] = '0;
      end
    end else begin
      // Wakeup of resident entries
      if (cdb_valid) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          for (int unsigned s = 0; s < NSRC; s++) begin
            if (valid_q[i] && !rdy_q[i][s] && tag_q[i][s] == cdb_tag) begin
              rdy_d[i][s] = 1'b1;
              val_d[i][s] = cdb_val;
            end
          end
        end
      end

      // Select into the issue register
      if (load_en) begin
        iss_valid_d = sel_found;
        if (sel_found) begin
          iss_operand_d = op_q[sel_idx];
          iss_wbs_d     = wbs_q[sel_idx];
          iss_flag_d    = flag_q[sel_idx];
          iss_robid_d   = robid_q[sel_idx];
          for (int unsigned s = 0; s < NSRC; s++) begin
            iss_srcval_d[s*DATAW +: DATAW] = val_q[sel_idx][s];
          end
        end else begin
          iss_operand_d = '0;
          iss_wbs_d     = '0;
          iss_flag_d    = '0;
          iss_robid_d   = '0;
          iss_srcval_d  = '0;
        end
      end
      if (do_sel) begin
        valid_d[sel_idx] = 1'b0;
      end

      // Dispatch into the lowest free slot; it becomes younger than everyone
      if (do_disp) begin
        valid_d[free_idx] = 1'b1;
        op_d[free_idx]    = disp_operand;
        wbs_d[free_idx]   = disp_wbs;
        flag_d[free_idx]  = disp_flag;
        robid_d[free_idx] = disp_robid;
        older_d[free_idx] = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (IDXW'(j) != free_idx) begin
            older_d[j][free_idx] = 1'b1;
          end
        end
        for (int unsigned s = 0; s < NSRC; s++) begin
          tag_d[free_idx][s] = disp_srctag[s*TAGW +: TAGW];
          if (disp_srcrdy[s]) begin
            rdy_d[free_idx][s] = 1'b1;
            val_d[free_idx][s] = disp_srcval[s*DATAW +: DATAW];
          end else if (cdb_valid && disp_srctag[s*TAGW +: TAGW] == cdb_tag) begin
            rdy_d[free_idx][s] = 1'b1;
            val_d[free_idx][s] = cdb_val;
          end else begin
            rdy_d[free_idx][s] = 1'b0;
            val_d[free_idx][s] = '0;
          end
        end
      end

      occ_d = occ_q + OCCW'(do_disp) - OCCW'(do_sel);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q       <= '0;
      iss_valid_q   <= 1'b0;
      iss_operand_q <= '0;
      iss_wbs_q     <= '0;
      iss_flag_q    <= '0;
      iss_robid_q   <= '0;
      iss_srcval_q  <= '0;
      occ_q         <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        wbs_q[i]   <= '0;
        flag_q[i]  <= '0;
        robid_q[i] <= '0;
        rdy_q[i]   <= '0;
        older_q[i] <= '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
          tag_q[i][s] <= '0;
          val_q[i][s] <= '0;
        end
      end
    end else begin
      valid_q       <= valid_d;
      op_q          <= op_d;
      wbs_q         <= wbs_d;
      flag_q        <= flag_d;
      robid_q       <= robid_d;
      rdy_q         <= rdy_d;
      tag_q         <= tag_d;
      val_q         <= val_d;
      older_q       <= older_d;
      iss_valid_q   <= iss_valid_d;
      iss_operand_q <= iss_operand_d;
      iss_wbs_q     <= iss_wbs_d;
      iss_flag_q    <= iss_flag_d;
      iss_robid_q   <= iss_robid_d;
      iss_srcval_q  <= iss_srcval_d;
      occ_q         <= occ_d;
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Bench for rs_bank: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations and randomized traffic.
module tb_rs_bank;
  localparam int DEPTH = 4;
  localparam int NSRC  = 2;
  localparam int TAGW  = 4;
  localparam int DATAW = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    disp_valid;
  logic                    disp_ready;
  logic [DATAW-1:0]        disp_operand, disp_wbs, disp_flag, disp_robid;
  logic [NSRC*TAGW-1:0]    disp_srctag;
  logic [NSRC-1:0]         disp_srcrdy;
  logic [NSRC*DATAW-1:0]   disp_srcval;
  logic                    cdb_valid;
  logic [TAGW-1:0]         cdb_tag;
  logic [DATAW-1:0]        cdb_val;
  logic                    iss_valid;
  logic                    iss_ready;
  logic [DATAW-1:0]        iss_operand, iss_wbs, iss_flag, iss_robid;
  logic [NSRC*DATAW-1:0]   iss_srcval;
  logic                    flush;
  logic [$clog2(DEPTH):0]  occupancy;

  always #5 clk = ~clk;

  rs_bank #(.DEPTH(DEPTH), .NSRC(NSRC), .TAGW(TAGW), .DATAW(DATAW)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_operand(disp_operand), .disp_wbs(disp_wbs), .disp_flag(disp_flag),
    .disp_robid(disp_robid), .disp_srctag(disp_srctag), .disp_srcrdy(disp_srcrdy),
    .disp_srcval(disp_srcval),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_operand(iss_operand), .iss_wbs(iss_wbs), .iss_flag(iss_flag),
    .iss_robid(iss_robid), .iss_srcval(iss_srcval),
    .flush(flush), .occupancy(occupancy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: stations kept as a list in dispatch order
  typedef struct packed {
    logic [DATAW-1:0]      operand;
    logic [DATAW-1:0]      wbs;
    logic [DATAW-1:0]      flag;
    logic [DATAW-1:0]      robid;
    logic [NSRC-1:0]       rdy;
    logic [NSRC*TAGW-1:0]  tag;
    logic [NSRC*DATAW-1:0] val;
  } ent_t;

  ent_t mq[$];
  ent_t m_iss  = '0;
  bit   m_iss_v = 0;

  always @(posedge clk or negedge rst) begin : model_blk
    int   sel;
    bit   room;
    ent_t e;
    if (!rst || flush) begin
      mq.delete();
      m_iss_v = 0;
      m_iss   = '0;
    end else begin
      room = mq.size() < DEPTH;
      sel  = -1;
      for (int k = 0; k < mq.size(); k++)
        if (sel < 0 && (&mq[k].rdy)) sel = k;
      if (cdb_valid) begin
        for (int k = 0; k < mq.size(); k++) begin
          e = mq[k];
          for (int s = 0; s < NSRC; s++)
            if (!e.rdy[s] && e.tag[s*TAGW +: TAGW] == cdb_tag) begin
              e.rdy[s] = 1'b1;
              e.val[s*DATAW +: DATAW] = cdb_val;
            end
          mq[k] = e;
        end
      end
      if (!m_iss_v || iss_ready) begin
        if (sel >= 0) begin
          m_iss   = mq[sel];
          m_iss_v = 1;
          mq.delete(sel);
        end else begin
          m_iss   = '0;
          m_iss_v = 0;
        end
      end
      if (disp_valid && room) begin
        e = '0;
        e.operand = disp_operand;
        e.wbs     = disp_wbs;
        e.flag    = disp_flag;
        e.robid   = disp_robid;
        e.tag     = disp_srctag;
        for (int s = 0; s < NSRC; s++) begin
          if (disp_srcrdy[s]) begin
            e.rdy[s] = 1'b1;
            e.val[s*DATAW +: DATAW] = disp_srcval[s*DATAW +: DATAW];
          end else if (cdb_valid && disp_srctag[s*TAGW +: TAGW] == cdb_tag) begin
            e.rdy[s] = 1'b1;
            e.val[s*DATAW +: DATAW] = cdb_val;
          end
        end
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_disp_ready", disp_ready, mq.size() < DEPTH);
      chk("m_occupancy", occupancy, mq.size());
      chk("m_iss_valid", iss_valid, m_iss_v);
      chk("m_iss_operand", iss_operand, m_iss.operand);
      chk("m_iss_wbs", iss_wbs, m_iss.wbs);
      chk("m_iss_flag", iss_flag, m_iss.flag);
      chk("m_iss_robid", iss_robid, m_iss.robid);
      chk("m_iss_srcval", iss_srcval, m_iss.val);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    disp_valid = 0;
    cdb_valid  = 0;
    flush      = 0;
  endtask

  task automatic put(input logic [7:0] rid, input logic [NSRC-1:0] rdy,
                     input logic [NSRC*TAGW-1:0] tg, input logic [NSRC*DATAW-1:0] v);
    disp_valid   = 1;
    disp_robid   = rid;
    disp_operand = rid ^ 8'h5A;
    disp_wbs     = rid + 8'd1;
    disp_flag    = ~rid;
    disp_srcrdy  = rdy;
    disp_srctag  = tg;
    disp_srcval  = v;
  endtask

  initial begin
    rst = 0;
    quiet();
    iss_ready = 0;
    disp_operand = '0; disp_wbs = '0; disp_flag = '0; disp_robid = '0;
    disp_srctag = '0; disp_srcrdy = '0; disp_srcval = '0;
    cdb_tag = '0; cdb_val = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_iss_robid", iss_robid, 0);
    chk_en = 1;
    rst = 1;
    step();

    // Ready-at-dispatch latency
    iss_ready = 1;
    put(8'h11, 2'b11, '0, 16'h0507);
    step(); quiet();
    chk("d039_occ", occupancy, 1);
    chk("d039_early", iss_valid, 0);
    step();
    chk("d039_valid", iss_valid, 1);
    chk("d039_robid", iss_robid, 8'h11);
    chk("d039_srcval", iss_srcval, 16'h0507);
    step();
    chk("d039_drain", iss_valid, 0);

    // CDB wakeup; a tag with cdb_valid low must not wake
    put(8'h21, 2'b10, {4'h0, 4'h3}, 16'h9900);
    step(); quiet();
    cdb_tag = 4'h3; cdb_val = 8'h55;
    step();
    chk("d040_nowake1", iss_valid, 0);
    cdb_valid = 1; cdb_val = 8'hAA;
    step(); quiet();
    chk("d040_nowake2", iss_valid, 0);
    step();
    chk("d040_valid", iss_valid, 1);
    chk("d040_robid", iss_robid, 8'h21);
    chk("d040_srcval", iss_srcval, 16'h99AA);
    step();

    // Fill, full, out-of-index-order wakeup
    for (int k = 0; k < 4; k++) begin
      put(8'(8'h41 + k), 2'b10, {4'h0, 4'(k + 1)}, 16'h1000);
      step();
      chk("d041_fill_occ", occupancy, k + 1);
    end
    quiet();
    chk("d041_full", disp_ready, 0);
    put(8'h4F, 2'b11, '0, 16'h0000);
    cdb_valid = 1; cdb_tag = 4'h4; cdb_val = 8'hC4;
    step(); quiet();
    chk("d041_occ4", occupancy, 4);
    chk("d041_noiss", iss_valid, 0);
    cdb_valid = 1; cdb_tag = 4'h2; cdb_val = 8'hC2;
    step(); quiet();
    chk("d041_robid1", iss_robid, 8'h44);
    chk("d041_src1", iss_srcval, 16'h10C4);
    chk("d041_occ3", occupancy, 3);
    chk("d041_ready", disp_ready, 1);
    step();
    chk("d041_robid2", iss_robid, 8'h42);
    chk("d041_src2", iss_srcval, 16'h10C2);
    chk("d041_occ2", occupancy, 2);

    // Flush with resident entries, held issue register and a concurrent dispatch
    iss_ready = 0;
    flush = 1;
    put(8'h4E, 2'b11, '0, 16'h1234);
    step(); quiet();
    chk("d044_occ", occupancy, 0);
    chk("d044_valid", iss_valid, 0);
    chk("d044_robid", iss_robid, 0);
    chk("d044_srcval", iss_srcval, 0);
    chk("d044_ready", disp_ready, 1);
    cdb_valid = 1; cdb_tag = 4'h1; cdb_val = 8'h77;
    step(); quiet();
    iss_ready = 1;
    step();
    chk("d044_after_valid", iss_valid, 0);
    chk("d044_after_occ", occupancy, 0);

    // Same-cycle CDB bypass at dispatch
    put(8'h52, 2'b10, {4'h0, 4'h5}, 16'h1100);
    cdb_valid = 1; cdb_tag = 4'h5; cdb_val = 8'h3C;
    step(); quiet();
    chk("d042_occ", occupancy, 1);
    chk("d042_early", iss_valid, 0);
    step();
    chk("d042_valid", iss_valid, 1);
    chk("d042_robid", iss_robid, 8'h52);
    chk("d042_srcval", iss_srcval, 16'h113C);
    step();

    // Back-pressure hold, then back-to-back issue in age order
    iss_ready = 0;
    for (int k = 0; k < 3; k++) begin
      put(8'(8'h61 + k), 2'b11, '0, {8'(8'h60 + k), 8'(8'h06 + k)});
      step();
    end
    quiet();
    chk("d043_robid0", iss_robid, 8'h61);
    chk("d043_occ0", occupancy, 2);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("d043_hold_valid", iss_valid, 1);
      chk("d043_hold_robid", iss_robid, 8'h61);
      chk("d043_hold_src", iss_srcval, 16'h6006);
    end
    iss_ready = 1;
    step();
    chk("d043_robid1", iss_robid, 8'h62);
    step();
    chk("d043_robid2", iss_robid, 8'h63);
    chk("d043_occ2", occupancy, 0);
    step();
    chk("d043_empty", iss_valid, 0);

    // Asynchronous reset mid-stream
    iss_ready = 0;
    put(8'h71, 2'b11, '0, 16'h0101);
    step();
    put(8'h72, 2'b10, {4'h0, 4'h6}, 16'h0200);
    step();
    put(8'h73, 2'b10, {4'h0, 4'h7}, 16'h0300);
    step(); quiet();
    chk("d044r_robid", iss_robid, 8'h71);
    chk("d044r_occ", occupancy, 2);
    rst = 0;
    #1;
    chk("d044r_valid", iss_valid, 0);
    chk("d044r_occ0", occupancy, 0);
    chk("d044r_robid0", iss_robid, 0);
    chk("d044r_ready", disp_ready, 1);
    #1;
    rst = 1;
    cdb_valid = 1; cdb_tag = 4'h6; cdb_val = 8'h66;
    step(); quiet();
    iss_ready = 1;
    step();
    chk("d044r_after_valid", iss_valid, 0);
    chk("d044r_after_occ", occupancy, 0);

    // Randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      disp_valid = ($urandom_range(0, 9) < 6);
      put(8'($urandom), 2'($urandom), {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))},
          16'($urandom));
      disp_valid   = ($urandom_range(0, 9) < 6);
      cdb_valid    = ($urandom_range(0, 9) < 4);
      cdb_tag      = 4'($urandom_range(0, 5));
      cdb_val      = 8'($urandom);
      iss_ready    = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 49) == 0);
      step();
      if ($urandom_range(0, 299) == 0) begin
        rst = 0;
        #2;
        rst = 1;
      end
    end
    quiet();
    iss_ready = 1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
